// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM states and divisor floor.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_duty_fix.sv
// Odd-divisor duty correction: a negedge copy of the posedge clock register,
// ORed back in to stretch the high phase by half a clk period.
module clk_div_duty_fix (
  input  logic clk,
  input  logic rst,
  input  logic odd_en,
  input  logic clk_pos,
  output logic clk_out
);

  logic neg_q;

  always_ff @(negedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= clk_pos;
  end

  assign clk_out = clk_pos | (neg_q & odd_en);

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with load/ack divisor handshake.
// Optional ODD_DUTY50_EN: exact 50% duty for odd divisors via clk_div_duty_fix.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] active_div,
  output logic             clk_out,
  output logic             tick,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_val;
  logic             pend_vld;
  logic             clk_q;

  logic             wrap;
  logic             apply;
  logic             clamp;
  logic [WIDTH-1:0] new_div;

  // Pending divisor lands only where cnt restarts at 0; IDLE holds cnt at 0.
  always_comb begin
    wrap    = (state == RUN) && (cnt == active_div - 1'b1);
    apply   = pend_vld && ((state == IDLE) || (en && wrap));
    clamp   = (pend_val < MIN_DIV_W);
    new_div = active_div;
    if (apply) new_div = clamp ? MIN_DIV_W : pend_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      active_div <= DEF_DIV_W;
      pend_val   <= '0;
      pend_vld   <= 1'b0;
      clk_q      <= 1'b0;
      tick       <= 1'b0;
      div_ack    <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      active_div <= new_div;
      div_ack    <= apply;
      if (apply && clamp) div_err <= 1'b1;

      // A load on the applying edge refills pending for the following boundary.
      if (div_load) begin
        pend_val <= div_val;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= RUN;
            clk_q <= 1'b1;
            tick  <= 1'b1;
          end else begin
            clk_q <= 1'b0;
            tick  <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            clk_q <= 1'b0;
            tick  <= 1'b0;
          end else if (wrap) begin
            cnt   <= '0;
            clk_q <= 1'b1;
            tick  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            clk_q <= ((cnt + 1'b1) < (new_div >> 1));
            tick  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          clk_q <= 1'b0;
          tick  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ODD_DUTY50_EN
  clk_div_duty_fix u_duty_fix (
    .clk     (clk),
    .rst     (rst),
    .odd_en  (active_div[0]),
    .clk_pos (clk_q),
    .clk_out (clk_out)
  );
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a period/phase reference model predicts
// every cycle's outputs; a monitor pops and compares after each posedge.
module tb_clk_div_prog;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEF_DIV = 3;

  logic             clk = 1'b0;
  logic             rst, en, div_load;
  logic [WIDTH-1:0] div_val;
  logic             div_ack, clk_out, tick, div_err;
  logic [WIDTH-1:0] active_div;

  typedef struct {
    bit tick;
    bit clk_out;
    bit ack;
    int div;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  bit m_run, m_pend_v, m_pos, m_err, m_tick, m_ack;
  int m_phase, m_div, m_pend;

  clk_div_prog #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .active_div (active_div),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_err    (div_err)
  );

  always #5 clk = ~clk;

  // One clk period of the divider: output high for the first floor(div/2)
  // cycles of each period; divisor changes only at period starts.
  task automatic step(input bit r, input bit e, input bit ld, input int v);
    exp_t x;
    bit   prev_pos, neg;
    bit   boundary;
    int   old_div;
    rst = r; en = e; div_load = ld; div_val = v[WIDTH-1:0];
    prev_pos = m_pos;
    neg      = r ? 1'b0 : prev_pos;
    if (r) begin
      m_run = 0; m_phase = 0; m_div = DEF_DIV; m_pend_v = 0; m_pend = 0;
      m_pos = 0; m_err = 0; m_tick = 0; m_ack = 0;
    end else begin
      old_div  = m_div;
      boundary = !m_run || (e && m_phase == old_div - 1);
      m_ack    = 0;
      m_tick   = 0;
      if (boundary && m_pend_v) begin
        m_div    = (m_pend < 2) ? 2 : m_pend;
        if (m_pend < 2) m_err = 1;
        m_ack    = 1;
        m_pend_v = 0;
      end
      if (ld) begin m_pend_v = 1; m_pend = v; end
      if (!e) begin
        m_run = 0; m_phase = 0;
      end else if (!m_run || m_phase == old_div - 1) begin
        m_run = 1; m_phase = 0; m_tick = 1;
      end else begin
        m_phase++;
      end
      m_pos = m_run && (m_phase < m_div / 2);
    end
    x.tick = m_tick; x.ack = m_ack; x.div = m_div; x.err = m_err;
`ifdef ODD_DUTY50_EN
    x.clk_out = m_pos | (neg & (m_div % 2 == 1));
`else
    x.clk_out = m_pos;
`endif
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_phase(input int ph);
    for (int unsigned i = 0; i < 600; i++) begin
      if (m_run && m_phase == ph) return;
      step(0, 1, 0, 0);
    end
    n_checks++; n_errors++;
    $display("FAIL phase_wait: model phase %0d required %0d within budget", m_phase, ph);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end else begin
        x = exp_q.pop_front();
        chk("tick",       int'(tick),       int'(x.tick));
        chk("clk_out",    int'(clk_out),    int'(x.clk_out));
        chk("div_ack",    int'(div_ack),    int'(x.ack));
        chk("active_div", int'(active_div), x.div);
        chk("div_err",    int'(div_err),    int'(x.err));
      end
    end
  end

  // stimulus
  initial begin
    int v;
    // 1/2: reset with en high, then free-run at the default divisor
    for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int unsigned i = 0; i < 9; i++) step(0, 1, 0, 0);
    // 3: load 4 at cnt=1, expect it at the next wrap
    run_until_phase(1);
    step(0, 1, 1, 4);
    for (int unsigned i = 0; i < 10; i++) step(0, 1, 0, 0);
    // 4: illegal divisor clamps to 2 and latches div_err
    step(0, 1, 1, 0);
    for (int unsigned i = 0; i < 10; i++) step(0, 1, 0, 0);
    // load coincident with a wrap edge waits for the following wrap
    run_until_phase(1);
    step(0, 1, 1, 6);
    for (int unsigned i = 0; i < 8; i++) step(0, 1, 0, 0);
    run_until_phase(5);
    step(0, 1, 1, 3);
    for (int unsigned i = 0; i < 10; i++) step(0, 1, 0, 0);
    // 5: N=5, stop at cnt=1, restart
    step(0, 1, 1, 5);
    for (int unsigned i = 0; i < 8; i++) step(0, 1, 0, 0);
    run_until_phase(1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int unsigned i = 0; i < 6; i++) step(0, 1, 0, 0);
    // load while idle is applied on the next edge; last load wins
    step(0, 0, 1, 9);
    step(0, 0, 1, 7);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    // maximum divisor
    step(0, 1, 1, 255);
    for (int unsigned i = 0; i < 520; i++) step(0, 1, 0, 0);
    // 6: reset discards a pending 7
    step(0, 1, 1, 7);
    step(1, 1, 0, 0);
    for (int unsigned i = 0; i < 20; i++) step(0, 1, 0, 0);
    // randomized traffic
    for (int unsigned i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 30)      v = $urandom_range(0, 1);
      else if ($urandom_range(0, 49) == 0) v = 255;
      else                                 v = $urandom_range(2, 12);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 96),
           ($urandom_range(0, 11) == 0), v);
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
